nios2_div_cell: RTL and testbench

//  Iterative radix-2 restoring integer divider for the Nios II A-stage datapath.

---
 rtl/nios2_div_pkg.sv | 21 ++
 rtl/nios2_div_cell_if.sv | 37 +++
 rtl/nios2_div_step.sv | 25 ++
 rtl/nios2_div_cell.sv | 170 +++++++++++++++++
 tb/tb_nios2_div_cell.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/nios2_div_pkg.sv
// Shared types and helpers for the Nios II iterative divide cell.
// Holds the FSM state encoding, the default operand width and two's-complement negation.
package nios2_div_pkg;

  localparam int DIV_WIDTH_DEFAULT = 32;

  // neg2c works on a fixed wide vector; callers cast their operand in and out.
  localparam int NEG_MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  function automatic logic [NEG_MAX_WIDTH-1:0] neg2c(input logic [NEG_MAX_WIDTH-1:0] x);
    return ~x + {{(NEG_MAX_WIDTH-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/nios2_div_cell_if.sv
// A-stage divide request/response bundle between the CPU (master) and the divide cell (slave).
interface nios2_div_cell_if #(
  parameter int WIDTH = nios2_div_pkg::DIV_WIDTH_DEFAULT
);

  logic             A_div_start;
  logic [WIDTH-1:0] A_div_src1;
  logic [WIDTH-1:0] A_div_src2;
  logic             A_div_signed;
  logic             A_div_rem_sel;
  logic             A_div_busy;
  logic             A_div_done;
  logic [WIDTH-1:0] A_div_result;

  modport master (
    output A_div_start,
    output A_div_src1,
    output A_div_src2,
    output A_div_signed,
    output A_div_rem_sel,
    input  A_div_busy,
    input  A_div_done,
    input  A_div_result
  );

  modport slave (
    input  A_div_start,
    input  A_div_src1,
    input  A_div_src2,
    input  A_div_signed,
    input  A_div_rem_sel,
    output A_div_busy,
    output A_div_done,
    output A_div_result
  );

endinterface

// File: rtl/nios2_div_step.sv
// One restoring-division iteration: shift {R,Q} left, trial-subtract D, keep or restore.
module nios2_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;
  logic             borrow;

  // R stays below D, so the shifted value never reaches bit WIDTH+1 and that bit acts as the borrow.
  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    trial   = shifted - {2'b00, div_i};
    borrow  = trial[WIDTH+1];
    rem_o   = borrow ? shifted[WIDTH:0] : trial[WIDTH:0];
    quo_o   = {quo_i[WIDTH-2:0], ~borrow};
  end

endmodule

// File: rtl/nios2_div_cell.sv
// Iterative radix-2 restoring divider beside the Nios II multiply cell; fixed WIDTH+3 cycle latency.
// Define NIOS2_DIV_SIGNED_EN to honour A_div_signed; otherwise every operation is unsigned.
module nios2_div_cell
  import nios2_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  nios2_div_cell_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_t       state_q,   state_d;
  logic [CNT_W-1:0] count_q,   count_d;
  logic [WIDTH:0]   rem_q,     rem_d;
  logic [WIDTH-1:0] quo_q,     quo_d;
  logic [WIDTH-1:0] dvs_q,     dvs_d;
  logic             remSel_q,  remSel_d;
  logic             divZero_q, divZero_d;
  logic [WIDTH-1:0] result_q,  result_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;

  logic [WIDTH:0]   stepRem;
  logic [WIDTH-1:0] stepQuo;
  logic [WIDTH-1:0] src1Mag;
  logic [WIDTH-1:0] src2Mag;
  logic [WIDTH-1:0] quoFix;
  logic [WIDTH-1:0] remFix;
  logic             accept;

`ifdef NIOS2_DIV_SIGNED_EN
  logic src1Neg;
  logic src2Neg;
  logic quoNeg_q, quoNeg_d;
  logic remNeg_q, remNeg_d;

  assign src1Neg = bus.A_div_signed & bus.A_div_src1[WIDTH-1];
  assign src2Neg = bus.A_div_signed & bus.A_div_src2[WIDTH-1];
  assign src1Mag = src1Neg ? WIDTH'(neg2c(NEG_MAX_WIDTH'(bus.A_div_src1))) : bus.A_div_src1;
  assign src2Mag = src2Neg ? WIDTH'(neg2c(NEG_MAX_WIDTH'(bus.A_div_src2))) : bus.A_div_src2;
`else
  logic unusedSigned;

  assign unusedSigned = bus.A_div_signed;
  assign src1Mag      = bus.A_div_src1;
  assign src2Mag      = bus.A_div_src2;
`endif

  nios2_div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .div_i (dvs_q),
    .rem_o (stepRem),
    .quo_o (stepQuo)
  );

  // A divisor of zero already yields an all-ones quotient; forcing it keeps the sign fix from touching it.
  always_comb begin
    quoFix = divZero_q ? '1 : quo_q;
    remFix = rem_q[WIDTH-1:0];
`ifdef NIOS2_DIV_SIGNED_EN
    if (!divZero_q && quoNeg_q) begin
      quoFix = WIDTH'(neg2c(NEG_MAX_WIDTH'(quo_q)));
    end
    if (remNeg_q) begin
      remFix = WIDTH'(neg2c(NEG_MAX_WIDTH'(rem_q[WIDTH-1:0])));
    end
`endif
  end

  // The done pulse is still in flight for one cycle after DONE, so a start then is also refused.
  assign accept = (state_q == IDLE) && bus.A_div_start && !done_q;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    remSel_d  = remSel_q;
    divZero_d = divZero_q;
    result_d  = result_q;
    done_d    = 1'b0;
`ifdef NIOS2_DIV_SIGNED_EN
    quoNeg_d  = quoNeg_q;
    remNeg_d  = remNeg_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = CALC;
          count_d   = CNT_W'(WIDTH - 1);
          rem_d     = '0;
          quo_d     = src1Mag;
          dvs_d     = src2Mag;
          remSel_d  = bus.A_div_rem_sel;
          divZero_d = (bus.A_div_src2 == '0);
`ifdef NIOS2_DIV_SIGNED_EN
          quoNeg_d  = src1Neg ^ src2Neg;
          remNeg_d  = src1Neg;
`endif
        end
      end
      CALC: begin
        rem_d   = stepRem;
        quo_d   = stepQuo;
        count_d = count_q - CNT_W'(1);
        if (count_q == '0) begin
          state_d = FIX;
        end
      end
      FIX: begin
        result_d = remSel_q ? remFix : quoFix;
        state_d  = DONE;
      end
      DONE: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      remSel_q  <= 1'b0;
      divZero_q <= 1'b0;
      result_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef NIOS2_DIV_SIGNED_EN
      quoNeg_q  <= 1'b0;
      remNeg_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      remSel_q  <= remSel_d;
      divZero_q <= divZero_d;
      result_q  <= result_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef NIOS2_DIV_SIGNED_EN
      quoNeg_q  <= quoNeg_d;
      remNeg_q  <= remNeg_d;
`endif
    end
  end

  assign bus.A_div_busy   = busy_q;
  assign bus.A_div_done   = done_q;
  assign bus.A_div_result = result_q;

endmodule

// File: tb/tb_nios2_div_cell.sv
// Directed bench for nios2_div_cell; expected values are hand-computed per build (NIOS2_DIV_SIGNED_EN).
module tb_nios2_div_cell;

  localparam int WIDTH    = 32;
  localparam int LATENCY  = WIDTH + 3;
  localparam int MAX_WAIT = 100;

  logic clk = 1'b0;
  logic reset;
  int   errorCount = 0;
  int   checkCount = 0;

  nios2_div_cell_if #(.WIDTH(WIDTH)) divBus ();

  nios2_div_cell #(
    .WIDTH (WIDTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (divBus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                             input logic [WIDTH-1:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Issue one divide, scramble the inputs while busy, optionally re-pulse start at cycle glitchAt.
  task automatic applyStimulus(input string tag, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input logic sgn, input logic remSel,
                               input int glitchAt, output logic [WIDTH-1:0] result,
                               output int latency);
    int cycles;
    @(negedge clk);
    divBus.A_div_src1    = a;
    divBus.A_div_src2    = b;
    divBus.A_div_signed  = sgn;
    divBus.A_div_rem_sel = remSel;
    divBus.A_div_start   = 1'b1;
    @(negedge clk);
    divBus.A_div_start   = 1'b0;
    divBus.A_div_src1    = $urandom;
    divBus.A_div_src2    = $urandom;
    divBus.A_div_signed  = 1'($urandom_range(0, 1));
    divBus.A_div_rem_sel = ~remSel;
    checkOutput({tag, "_busy"}, divBus.A_div_busy, 1);
    cycles = 1;
    while (divBus.A_div_done !== 1'b1 && cycles < MAX_WAIT) begin
      divBus.A_div_start = (cycles == glitchAt);
      @(negedge clk);
      cycles++;
    end
    divBus.A_div_start = 1'b0;
    if (divBus.A_div_done !== 1'b1) begin
      checkOutput({tag, "_timeout"}, 0, 1);
    end
    checkOutput({tag, "_busy_at_done"}, divBus.A_div_busy, 0);
    result  = divBus.A_div_result;
    latency = cycles;
  endtask

  // Called in the done cycle: a start here must be dropped and nothing else may happen.
  task automatic checkQuiet(input string tag, input logic [WIDTH-1:0] expResult);
    int donePulses = 0;
    int busySeen   = 0;
    divBus.A_div_src1    = 77;
    divBus.A_div_src2    = 1;
    divBus.A_div_rem_sel = 1'b0;
    divBus.A_div_start   = 1'b1;
    @(negedge clk);
    divBus.A_div_start   = 1'b0;
    for (int i = 0; i < LATENCY + 4; i++) begin
      if (divBus.A_div_done === 1'b1) donePulses++;
      if (divBus.A_div_busy === 1'b1) busySeen++;
      @(negedge clk);
    end
    checkOutput({tag, "_extra_done"}, donePulses, 0);
    checkOutput({tag, "_busy"}, busySeen, 0);
    checkOutput({tag, "_result_held"}, divBus.A_div_result, expResult);
  endtask

  initial begin
    logic [WIDTH-1:0] res;
    int               lat;
    logic [WIDTH-1:0] expQ;
    logic [WIDTH-1:0] expR;

    reset                = 1'b1;
    divBus.A_div_start   = 1'b0;
    divBus.A_div_src1    = '0;
    divBus.A_div_src2    = '0;
    divBus.A_div_signed  = 1'b0;
    divBus.A_div_rem_sel = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", divBus.A_div_busy, 0);
    checkOutput("reset_done", divBus.A_div_done, 0);
    checkOutput("reset_result", divBus.A_div_result, 0);
    reset = 1'b0;

    applyStimulus("u100_7_q", 100, 7, 1'b0, 1'b0, 0, res, lat);
    checkOutput("u100_7_q", res, 14);
    checkOutput("u100_7_latency", lat, LATENCY);
    applyStimulus("u100_7_r", 100, 7, 1'b0, 1'b1, 0, res, lat);
    checkOutput("u100_7_r", res, 2);

`ifdef NIOS2_DIV_SIGNED_EN
    expQ = 32'hFFFF_FFFD;
    expR = 32'hFFFF_FFFF;
`else
    expQ = 32'h7FFF_FFFC;
    expR = 32'h0000_0001;
`endif
    applyStimulus("s-7_2_q", 32'hFFFF_FFF9, 2, 1'b1, 1'b0, 0, res, lat);
    checkOutput("s-7_2_q", res, expQ);
    applyStimulus("s-7_2_r", 32'hFFFF_FFF9, 2, 1'b1, 1'b1, 0, res, lat);
    checkOutput("s-7_2_r", res, expR);

`ifdef NIOS2_DIV_SIGNED_EN
    expQ = 32'hFFFF_FFFD;
    expR = 32'h0000_0001;
`else
    expQ = 32'h0000_0000;
    expR = 32'h0000_0007;
`endif
    applyStimulus("s7_-2_q", 7, 32'hFFFF_FFFE, 1'b1, 1'b0, 0, res, lat);
    checkOutput("s7_-2_q", res, expQ);
    applyStimulus("s7_-2_r", 7, 32'hFFFF_FFFE, 1'b1, 1'b1, 0, res, lat);
    checkOutput("s7_-2_r", res, expR);

    applyStimulus("div0_q", 32'h1234, 0, 1'b0, 1'b0, 0, res, lat);
    checkOutput("div0_q", res, 32'hFFFF_FFFF);
    checkOutput("div0_latency", lat, LATENCY);
    applyStimulus("div0_r", 32'h1234, 0, 1'b0, 1'b1, 0, res, lat);
    checkOutput("div0_r", res, 32'h1234);
    applyStimulus("sdiv0_q", 32'hFFFF_FFFB, 0, 1'b1, 1'b0, 0, res, lat);
    checkOutput("sdiv0_q", res, 32'hFFFF_FFFF);
    applyStimulus("sdiv0_r", 32'hFFFF_FFFB, 0, 1'b1, 1'b1, 0, res, lat);
    checkOutput("sdiv0_r", res, 32'hFFFF_FFFB);

`ifdef NIOS2_DIV_SIGNED_EN
    expQ = 32'h8000_0000;
    expR = 32'h0000_0000;
`else
    expQ = 32'h0000_0000;
    expR = 32'h8000_0000;
`endif
    applyStimulus("ovf_q", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 0, res, lat);
    checkOutput("ovf_q", res, expQ);
    applyStimulus("ovf_r", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 0, res, lat);
    checkOutput("ovf_r", res, expR);

    applyStimulus("glitch_calc", 50, 5, 1'b0, 1'b0, 10, res, lat);
    checkOutput("glitch_calc", res, 10);
    checkOutput("glitch_calc_latency", lat, LATENCY);
    applyStimulus("glitch_done", 60, 5, 1'b0, 1'b0, LATENCY - 1, res, lat);
    checkOutput("glitch_done", res, 12);
    checkOutput("glitch_done_latency", lat, LATENCY);
    checkQuiet("quiet", 12);

    @(negedge clk);
    divBus.A_div_src1    = 1000;
    divBus.A_div_src2    = 3;
    divBus.A_div_signed  = 1'b0;
    divBus.A_div_rem_sel = 1'b0;
    divBus.A_div_start   = 1'b1;
    @(negedge clk);
    divBus.A_div_start   = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_busy", divBus.A_div_busy, 0);
    checkOutput("abort_done", divBus.A_div_done, 0);
    checkOutput("abort_result", divBus.A_div_result, 0);
    reset = 1'b0;

    applyStimulus("after_reset", 9, 3, 1'b0, 1'b0, 0, res, lat);
    checkOutput("after_reset", res, 3);
    checkOutput("after_reset_latency", lat, LATENCY);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
